// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: CPU request, loader burst and memory-side signals.
// The arbiter takes the slave view; requesters and memory take the master view.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_stall;
    logic [DATA_W-1:0] c_rdata;
    logic              c_rvalid;

    logic              l_start;
    logic [ADDR_W-1:0] l_base;
    logic [ADDR_W:0]   l_len;
    logic              l_wvalid;
    logic [DATA_W-1:0] l_wdata;
    logic              l_wready;
    logic              l_busy;
    logic              l_done;

    logic              WE_DM;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] Dout;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rdata, c_rvalid,
        input  l_start, l_base, l_len, l_wvalid, l_wdata,
        output l_wready, l_busy, l_done,
        output WE_DM, address1, data,
        input  Dout
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rdata, c_rvalid,
        output l_start, l_base, l_len, l_wvalid, l_wdata,
        input  l_wready, l_busy, l_done,
        input  WE_DM, address1, data,
        output Dout
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the data memory's single write/address1 port between the CPU
// MEM stage and a block loader that bursts writes over a word range.
module dm_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    dm_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0]     SMAX  = SW'(MAX_WAIT);
    localparam logic [SW-1:0]     S1    = SW'(1);
    localparam logic [ADDR_W-1:0] A1    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   R1    = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_n;
    logic [ADDR_W:0]   remaining, remaining_n;
    logic [SW-1:0]     starve_cnt, starve_n;
    logic              beat;
    logic              c_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            remaining  <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            addr_cnt   <= addr_cnt_n;
            remaining  <= remaining_n;
            starve_cnt <= starve_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.c_rvalid <= 1'b0;
            bus.c_rdata  <= '0;
        end else begin
            bus.c_rvalid <= c_load;
            if (c_load)
                bus.c_rdata <= bus.Dout;
        end
    end

    assign bus.l_busy = (state == BURST);
    assign bus.l_done = (state == DONE);
    assign c_load     = bus.c_gnt & ~bus.c_we;

    // A waiting loader beat wins once the CPU has pre-empted it MAX_WAIT times.
    always_comb begin
        beat = (state == BURST) && bus.l_wvalid &&
               (!bus.c_req || starve_cnt == SMAX);

        bus.c_gnt    = bus.c_req & ~beat;
        bus.c_stall  = bus.c_req & ~bus.c_gnt;
        bus.l_wready = beat;
        bus.WE_DM    = 1'b0;
        bus.address1 = addr_cnt;
        bus.data     = '0;

        if (beat) begin
            bus.WE_DM = 1'b1;
            bus.data  = bus.l_wdata;
        end else if (bus.c_gnt) begin
            bus.WE_DM    = bus.c_we;
            bus.address1 = bus.c_addr;
            bus.data     = bus.c_wdata;
        end
    end

    always_comb begin
        state_n     = state;
        addr_cnt_n  = addr_cnt;
        remaining_n = remaining;
        starve_n    = starve_cnt;

        unique case (state)
            IDLE: begin
                if (bus.l_start && bus.l_len != '0) begin
                    state_n     = BURST;
                    addr_cnt_n  = bus.l_base;
                    remaining_n = bus.l_len;
                    starve_n    = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    addr_cnt_n  = addr_cnt + A1;
                    remaining_n = remaining - R1;
                    starve_n    = '0;
                    if (remaining == R1)
                        state_n = DONE;
                end else if (bus.l_wvalid && bus.c_req &&
                             starve_cnt != SMAX) begin
                    starve_n = starve_cnt + S1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: memory model on the bus plus write and
// load-data scoreboards filled as stimulus is driven.
module tb_dm_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW+DW-1:0] act_wr [$];
    logic [AW+DW-1:0] exp_wr [$];
    logic [DW-1:0]    exp_rd [$];
    int errors = 0;
    int checks = 0;

    assign bus.Dout = mem[bus.address1];

    // Memory writes on the falling edge; every write is logged.
    always @(negedge clk) begin
        if (!rst && bus.WE_DM) begin
            mem[bus.address1] <= bus.data;
            act_wr.push_back({bus.address1, bus.data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_start = 0; bus.l_base = '0; bus.l_len = '0;
        bus.l_wvalid = 0; bus.l_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.l_busy); end
        checks++; if (bus.l_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.l_done); end
        checks++; if (bus.c_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", bus.c_rvalid); end
        checks++; if (bus.c_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", bus.c_rdata); end
        checks++; if (bus.WE_DM !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.WE_DM); end
        checks++; if (bus.address1 !== 10'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.address1); end
        checks++; if (bus.c_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=0", bus.c_gnt); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_cpu();
        logic [AW+DW-1:0] a, e;
        tick();
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 10'h005; bus.c_wdata = 32'hDEADBEEF;
        exp_wr.push_back({10'h005, 32'hDEADBEEF});
        #1;
        checks++; if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt got=%b exp=1", bus.c_gnt); end
        checks++; if (bus.c_stall !== 1'b0) begin errors++; $display("FAIL st_stall got=%b exp=0", bus.c_stall); end
        checks++; if (bus.WE_DM !== 1'b1) begin errors++; $display("FAIL st_we got=%b exp=1", bus.WE_DM); end
        checks++; if (bus.address1 !== 10'h005) begin errors++; $display("FAIL st_addr got=%h exp=005", bus.address1); end
        checks++; if (bus.data !== 32'hDEADBEEF) begin errors++; $display("FAIL st_data got=%h exp=deadbeef", bus.data); end
        tick();
        bus.c_we = 0;
        exp_rd.push_back(32'hDEADBEEF);
        #1;
        checks++; if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL ld_gnt got=%b exp=1", bus.c_gnt); end
        checks++; if (bus.WE_DM !== 1'b0) begin errors++; $display("FAIL ld_we got=%b exp=0", bus.WE_DM); end
        checks++; if (bus.c_rvalid !== 1'b0) begin errors++; $display("FAIL st_rvalid got=%b exp=0", bus.c_rvalid); end
        tick();
        bus.c_req = 0;
        #1;
        checks++; if (bus.c_rvalid !== 1'b1) begin errors++; $display("FAIL ld_rvalid got=%b exp=1", bus.c_rvalid); end
        e[DW-1:0] = exp_rd.pop_front();
        checks++; if (bus.c_rdata !== e[DW-1:0]) begin errors++; $display("FAIL ld_rdata got=%h exp=%h", bus.c_rdata, e[DW-1:0]); end
        tick();
        #1;
        checks++; if (bus.c_rvalid !== 1'b0) begin errors++; $display("FAIL ld_rvalid_drop got=%b exp=0", bus.c_rvalid); end
        checks++; if (bus.c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata_hold got=%h exp=deadbeef", bus.c_rdata); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL cpu_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL cpu_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_wrap();
        logic [AW+DW-1:0] a, e;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        int busy_cnt;
        busy_cnt = 0;
        tick();
        bus.l_start = 1; bus.l_base = 10'h3FE; bus.l_len = 11'd4;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 10'h005;
        exp_rd.push_back(32'hDEADBEEF);
        #1;
        checks++; if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL sim_gnt got=%b exp=1", bus.c_gnt); end
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL sim_busy got=%b exp=0", bus.l_busy); end
        ad = 10'h3FE;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.l_start = 0; bus.c_req = 0;
            bus.l_wvalid = 1; d = DW'(i + 1); bus.l_wdata = d;
            exp_wr.push_back({ad, d});
            #1;
            if (i == 0) begin
                d = exp_rd.pop_front();
                checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== d) begin errors++; $display("FAIL sim_ld got=%b/%h exp=1/%h", bus.c_rvalid, bus.c_rdata, d); end
            end
            busy_cnt += int'(bus.l_busy);
            checks++; if (bus.l_wready !== 1'b1) begin errors++; $display("FAIL wrap_wready%0d got=%b exp=1", i, bus.l_wready); end
            checks++; if (bus.address1 !== ad) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, bus.address1, ad); end
            ad = ad + 10'd1;
        end
        tick();
        bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", bus.l_done); end
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got=%b exp=0", bus.l_busy); end
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL wrap_busy_cycles got=%0d exp=4", busy_cnt); end
        checks++; if (bus.address1 !== 10'h002) begin errors++; $display("FAIL wrap_addr_cnt got=%h exp=002", bus.address1); end
        tick();
        #1;
        checks++; if (bus.l_done !== 1'b0) begin errors++; $display("FAIL wrap_done_pulse got=%b exp=0", bus.l_done); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL wrap_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL wrap_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_starve();
        logic [AW+DW-1:0] a, e;
        logic exp_l;
        int beats;
        beats = 0;
        tick();
        bus.l_start = 1; bus.l_base = 10'h100; bus.l_len = 11'd8;
        #1;
        for (int k = 0; k < 40; k++) begin
            tick();
            bus.l_start = 0;
            bus.c_req = 1; bus.c_we = 1;
            bus.c_addr = AW'(32'h200 + k); bus.c_wdata = 32'hC000_0000 + DW'(k);
            bus.l_wvalid = 1; bus.l_wdata = 32'hA0 + DW'(beats);
            #1;
            exp_l = (k % 5 == 4);
            checks++; if (bus.l_wready !== exp_l) begin errors++; $display("FAIL stv_wready%0d got=%b exp=%b", k, bus.l_wready, exp_l); end
            checks++; if (bus.c_gnt !== !exp_l) begin errors++; $display("FAIL stv_gnt%0d got=%b exp=%b", k, bus.c_gnt, !exp_l); end
            checks++; if (bus.c_stall !== exp_l) begin errors++; $display("FAIL stv_stall%0d got=%b exp=%b", k, bus.c_stall, exp_l); end
            if (exp_l) begin
                exp_wr.push_back({AW'(32'h100 + beats), 32'hA0 + DW'(beats)});
                beats++;
            end else begin
                exp_wr.push_back({AW'(32'h200 + k), 32'hC000_0000 + DW'(k)});
            end
        end
        tick();
        bus.c_req = 0; bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL stv_done got=%b exp=1", bus.l_done); end
        checks++; if (bus.c_rvalid !== 1'b0) begin errors++; $display("FAIL stv_rvalid got=%b exp=0", bus.c_rvalid); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL stv_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL stv_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_nowait();
        logic [AW+DW-1:0] a, e;
        logic [DW-1:0] d;
        tick();
        bus.l_start = 1; bus.l_base = 10'h050; bus.l_len = 11'd2;
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.l_start = 0; bus.l_wvalid = 0;
            bus.c_req = 1; bus.c_we = 0; bus.c_addr = AW'(32'h100 + k);
            #1;
            if (k > 0) begin
                d = exp_rd.pop_front();
                checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== d) begin errors++; $display("FAIL nw_ld%0d got=%b/%h exp=1/%h", k, bus.c_rvalid, bus.c_rdata, d); end
            end
            checks++; if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL nw_gnt%0d got=%b exp=1", k, bus.c_gnt); end
            checks++; if (bus.c_stall !== 1'b0) begin errors++; $display("FAIL nw_stall%0d got=%b exp=0", k, bus.c_stall); end
            checks++; if (bus.l_wready !== 1'b0) begin errors++; $display("FAIL nw_wready%0d got=%b exp=0", k, bus.l_wready); end
            exp_rd.push_back(32'hA0 + DW'(k));
        end
        tick();
        bus.l_wvalid = 1; bus.l_wdata = 32'h55; bus.c_addr = 10'h106;
        #1;
        d = exp_rd.pop_front();
        checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== d) begin errors++; $display("FAIL nw_ld6 got=%b/%h exp=1/%h", bus.c_rvalid, bus.c_rdata, d); end
        checks++; if (bus.c_gnt !== 1'b1 || bus.l_wready !== 1'b0) begin errors++; $display("FAIL nw_held gnt/wready got=%b/%b exp=1/0", bus.c_gnt, bus.l_wready); end
        exp_rd.push_back(32'hA6);
        tick();
        bus.c_req = 0;
        exp_wr.push_back({10'h050, 32'h55});
        #1;
        d = exp_rd.pop_front();
        checks++; if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== d) begin errors++; $display("FAIL nw_ld7 got=%b/%h exp=1/%h", bus.c_rvalid, bus.c_rdata, d); end
        checks++; if (bus.l_wready !== 1'b1 || bus.address1 !== 10'h050) begin errors++; $display("FAIL nw_beat0 got=%b/%h exp=1/050", bus.l_wready, bus.address1); end
        tick();
        bus.l_wdata = 32'h56;
        exp_wr.push_back({10'h051, 32'h56});
        #1;
        checks++; if (bus.l_wready !== 1'b1 || bus.address1 !== 10'h051) begin errors++; $display("FAIL nw_beat1 got=%b/%h exp=1/051", bus.l_wready, bus.address1); end
        tick();
        bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL nw_done got=%b exp=1", bus.l_done); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL nw_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL nw_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_reset_mid();
        logic [AW+DW-1:0] a, e;
        tick();
        bus.l_start = 1; bus.l_base = 10'h300; bus.l_len = 11'd6;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.l_start = 0; bus.l_wvalid = 1; bus.l_wdata = 32'h700 + DW'(i);
            exp_wr.push_back({AW'(32'h300 + i), 32'h700 + DW'(i)});
            #1;
            checks++; if (bus.l_wready !== 1'b1) begin errors++; $display("FAIL rm_wready%0d got=%b exp=1", i, bus.l_wready); end
        end
        tick();
        rst = 1; bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", bus.l_busy); end
        checks++; if (bus.WE_DM !== 1'b0) begin errors++; $display("FAIL rm_we got=%b exp=0", bus.WE_DM); end
        checks++; if (bus.c_rdata !== 32'h0) begin errors++; $display("FAIL rm_rdata got=%h exp=0", bus.c_rdata); end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++; if (bus.l_done !== 1'b0 || bus.l_busy !== 1'b0) begin errors++; $display("FAIL rm_hold%0d done/busy got=%b/%b exp=0/0", i, bus.l_done, bus.l_busy); end
        end
        tick();
        rst = 0;
        #1;
        checks++; if (bus.l_done !== 1'b0) begin errors++; $display("FAIL rm_nodone got=%b exp=0", bus.l_done); end
        tick();
        bus.l_start = 1; bus.l_base = 10'h310; bus.l_len = 11'd2;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.l_start = 0; bus.l_wvalid = 1; bus.l_wdata = 32'h800 + DW'(i);
            exp_wr.push_back({AW'(32'h310 + i), 32'h800 + DW'(i)});
            #1;
            checks++; if (bus.l_wready !== 1'b1 || bus.address1 !== AW'(32'h310 + i)) begin errors++; $display("FAIL rm_new%0d got=%b/%h exp=1/%h", i, bus.l_wready, bus.address1, AW'(32'h310 + i)); end
        end
        tick();
        bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL rm_new_done got=%b exp=1", bus.l_done); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rm_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL rm_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_ignored();
        logic [AW+DW-1:0] a, e;
        tick();
        bus.l_start = 1; bus.l_base = 10'h200; bus.l_len = 11'd0;
        bus.l_wvalid = 1; bus.l_wdata = 32'hBAD;
        #1;
        tick();
        bus.l_start = 0;
        #1;
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL ig_len0_busy got=%b exp=0", bus.l_busy); end
        checks++; if (bus.l_wready !== 1'b0 || bus.WE_DM !== 1'b0) begin errors++; $display("FAIL ig_len0_write got=%b/%b exp=0/0", bus.l_wready, bus.WE_DM); end
        tick();
        bus.l_start = 1; bus.l_base = 10'h3A0; bus.l_len = 11'd3; bus.l_wvalid = 0;
        #1;
        tick();
        bus.l_start = 1; bus.l_base = 10'h000; bus.l_len = 11'd5;
        #1;
        checks++; if (bus.l_busy !== 1'b1 || bus.WE_DM !== 1'b0) begin errors++; $display("FAIL ig_busy_start got=%b/%b exp=1/0", bus.l_busy, bus.WE_DM); end
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.l_start = 0; bus.l_wvalid = 1; bus.l_wdata = 32'h900 + DW'(i);
            exp_wr.push_back({AW'(32'h3A0 + i), 32'h900 + DW'(i)});
            #1;
            checks++; if (bus.l_wready !== 1'b1 || bus.address1 !== AW'(32'h3A0 + i)) begin errors++; $display("FAIL ig_beat%0d got=%b/%h exp=1/%h", i, bus.l_wready, bus.address1, AW'(32'h3A0 + i)); end
        end
        tick();
        bus.l_wvalid = 0;
        #1;
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL ig_done got=%b exp=1", bus.l_done); end
        checks++; if (bus.address1 !== 10'h3A3) begin errors++; $display("FAIL ig_addr_cnt got=%h exp=3a3", bus.address1); end
        tick();
        #1;
        checks++; if (bus.l_busy !== 1'b0) begin errors++; $display("FAIL ig_idle got=%b exp=0", bus.l_busy); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL ig_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL ig_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_full();
        logic [AW+DW-1:0] a, e;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        int nbeat;
        nbeat = 0;
        tick();
        bus.l_start = 1; bus.l_base = 10'h123; bus.l_len = 11'd1024;
        #1;
        ad = 10'h123;
        for (int i = 0; i < 1024; i++) begin
            tick();
            bus.l_start = 0; bus.l_wvalid = 1;
            d = 32'h5A5A_0000 | DW'(i); bus.l_wdata = d;
            exp_wr.push_back({ad, d});
            ad = ad + 10'd1;
            #1;
            nbeat += int'(bus.l_wready);
        end
        tick();
        bus.l_wvalid = 0;
        #1;
        checks++; if (nbeat != 1024) begin errors++; $display("FAIL full_beats got=%0d exp=1024", nbeat); end
        checks++; if (bus.l_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", bus.l_done); end
        checks++; if (bus.address1 !== 10'h123) begin errors++; $display("FAIL full_addr_cnt got=%h exp=123", bus.address1); end
        checks++; if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL full_wcount got=%0d exp=%0d", act_wr.size(), exp_wr.size()); end
        while (act_wr.size() > 0 && exp_wr.size() > 0) begin
            a = act_wr.pop_front(); e = exp_wr.pop_front();
            checks++; if (a !== e) begin errors++; $display("FAIL full_wr got=%h exp=%h", a, e); end
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_cpu();
        test_wrap();
        test_starve();
        test_nowait();
        test_reset_mid();
        test_ignored();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Sequences and shares the data memory's single write/address1 port between two requesters.
- Requester C is the CPU MEM stage: single-word load/store, stalls until granted.
- Requester L is a block loader (test/boot DMA) that fills a contiguous word range with a burst of writes.
- Sits between the pipeline/loader and the data memory. It drives WE_DM, address1 and data, and captures Dout. The memory's address2/Dout2 debug read path is untouched.

Parameters:
- ADDR_W, 10, word address width; the memory depth is 2^ADDR_W.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, maximum consecutive cycles a ready loader beat may be pre-empted by the CPU before the loader is forced through.

Ports:
- clk  in  1  system clock; state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU access request; held high until c_gnt.
- c_we  in  1  CPU access is a store.
- c_addr  in  ADDR_W  CPU word address.
- c_wdata  in  DATA_W  CPU store data.
- c_gnt  out  1  combinational; the CPU access is performed this cycle.
- c_stall  out  1  combinational; equals c_req & ~c_gnt.
- c_rdata  out  DATA_W  registered load data.
- c_rvalid  out  1  registered; c_rdata is valid this cycle.
- l_start  in  1  one-cycle burst start pulse.
- l_base  in  ADDR_W  burst start address, sampled with l_start.
- l_len  in  ADDR_W+1  burst length in words, 1..2^ADDR_W, sampled with l_start.
- l_wvalid  in  1  l_wdata is valid.
- l_wdata  in  DATA_W  loader write data.
- l_wready  out  1  combinational; the beat is written this cycle.
- l_busy  out  1  registered; a burst is in progress.
- l_done  out  1  registered; one-cycle pulse after the last beat.
- WE_DM  out  1  combinational memory write enable.
- address1  out  ADDR_W  combinational memory address.
- data  out  DATA_W  combinational memory write data.
- Dout  in  DATA_W  combinational memory read data for address1.

Behaviour:
- Reset: state=IDLE.
  - l_busy, l_done, c_rvalid are 0; c_rdata is 0.
  - Internal addr_cnt, remaining and starve_cnt are 0.
  - Async reset mid-burst aborts the burst immediately; no l_done is issued.
- The memory writes on the negedge of clk. WE_DM/address1/data are therefore driven combinationally in the same cycle as the grant, so the write lands in that cycle.
- When nobody is granted: WE_DM=0, address1=addr_cnt, data=0.
- States:
  - IDLE: c_gnt = c_req.
    - l_start with l_len != 0 latches addr_cnt=l_base, remaining=l_len, starve_cnt=0, and moves to BURST.
    - l_start with l_len=0 is ignored.
    - l_start while not in IDLE is ignored.
  - BURST, slot decision each cycle:
    - Loader beat when l_wvalid=1 and either c_req=0 or starve_cnt==MAX_WAIT.
    - Otherwise the CPU is granted if c_req=1.
    - If both are idle, the slot is empty.
  - BURST, loader beat:
    - l_wready=1; WE_DM=1, address1=addr_cnt, data=l_wdata.
    - addr_cnt increments modulo 2^ADDR_W, so address 1023 is followed by 0.
    - remaining decrements; starve_cnt clears.
    - If remaining==1, move to DONE.
  - BURST, CPU pre-empts a valid beat: starve_cnt increments, saturating at MAX_WAIT. With l_wvalid=0, starve_cnt holds.
  - DONE: one cycle; l_done=1; CPU may be granted as in IDLE; then move to IDLE.
  - l_busy=1 in BURST only.
- CPU access when granted: address1=c_addr, WE_DM=c_we, data=c_wdata.
  - For a load (c_we=0), Dout is captured into c_rdata at posedge and c_rvalid=1 in the next cycle. Latency from grant cycle to data is 1 cycle.
  - For a store, c_rvalid stays 0.
  - c_rdata holds its value when no load completes.
- Simultaneous l_start and c_req in IDLE: the CPU is granted that cycle; the burst starts next cycle.
- A CPU store and a loader beat to the same address never occur in the same cycle, because the port is single and arbitrated.
- A full-memory burst (l_len=1024) writes every word exactly once and ends with addr_cnt=l_base.

Test Plan:
- Reset then IDLE CPU store to 0x005 of 0xDEADBEEF, then a load from 0x005: c_gnt=1 both cycles; c_rvalid=1 one cycle after the load with c_rdata=0xDEADBEEF.
- Burst l_base=0x3FE, l_len=4, l_wvalid held 1, data 1..4, no CPU: words 0x3FE, 0x3FF, 0x000, 0x001 are written with 1..4; l_busy is high 4 cycles; l_done pulses in the 5th cycle.
- Burst l_len=8 with c_req held high continuously, MAX_WAIT=4: pattern is 4 CPU grants then 1 loader beat, repeating; c_stall=1 on the forced-loader cycles; all 8 words are written.
- l_wvalid low during a burst with c_req=1: CPU is granted with no stall; starve_cnt is unchanged.
- Assert rst mid-burst after 2 of 6 beats: l_busy=0 immediately; no l_done; after release, a new l_start burst works normally.
- l_start with l_len=0, and l_start while busy: both ignored; no writes; l_busy unchanged.
